// File: rtl/dtc_vote_collector.sv
// Windowed per-bit majority vote over classifier codes with valid/ready on both sides.
// Optional early emit via the flush port when DTC_VOTE_FLUSH_EN is defined.
module dtc_vote_collector #(
   parameter int WIDTH  = 7,
   parameter int WINDOW = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] inp,
   input  logic             inp_valid,
   output logic             inp_ready,
   output logic [WIDTH-1:0] outp,
   output logic             outp_valid,
   input  logic             outp_ready
`ifdef DTC_VOTE_FLUSH_EN
   ,
   input  logic             flush
`endif
);

   localparam int CW = $clog2(WINDOW + 1);

   typedef enum logic {
      ACCUM = 1'b0,
      EMIT  = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [CW-1:0]    n, n_next, n_inc;
   logic [CW-1:0]    cnt      [WIDTH];
   logic [CW-1:0]    cnt_next [WIDTH];
   logic [CW-1:0]    cnt_inc  [WIDTH];
   logic [WIDTH-1:0] vote;
   logic [WIDTH-1:0] outp_next;
   logic             outp_valid_next;
   logic             accept;
   logic             full;
   logic             flush_req;

   assign inp_ready = (state == ACCUM);

   always_comb begin
      accept = inp_valid && (state == ACCUM);
      n_inc  = n + CW'(accept);
      // Threshold is n_inc: equals WINDOW on a full window, the partial count on flush.
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_inc[i] = cnt[i] + CW'(accept && inp[i]);
         vote[i]    = ({cnt_inc[i], 1'b0} > {1'b0, n_inc});
      end
      full = accept && (n_inc == CW'(WINDOW));
`ifdef DTC_VOTE_FLUSH_EN
      flush_req = flush && (state == ACCUM) && (n_inc != '0);
`else
      flush_req = 1'b0;
`endif

      state_next      = state;
      n_next          = n;
      cnt_next        = cnt;
      outp_next       = outp;
      outp_valid_next = outp_valid;

      case (state)
         ACCUM: begin
            n_next   = n_inc;
            cnt_next = cnt_inc;
            if (full || flush_req) begin
               outp_next       = vote;
               outp_valid_next = 1'b1;
               state_next      = EMIT;
            end
         end
         EMIT: begin
            if (outp_ready) begin
               n_next          = '0;
               cnt_next        = '{default: '0};
               outp_valid_next = 1'b0;
               state_next      = ACCUM;
            end
         end
         default: state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ACCUM;
         n          <= '0;
         cnt        <= '{default: '0};
         outp       <= '0;
         outp_valid <= 1'b0;
      end else begin
         state      <= state_next;
         n          <= n_next;
         cnt        <= cnt_next;
         outp       <= outp_next;
         outp_valid <= outp_valid_next;
      end
   end

endmodule

// File: tb/tb_dtc_vote_collector.sv
// Scoreboard bench for dtc_vote_collector; flush cases build only with DTC_VOTE_FLUSH_EN.
module tb_dtc_vote_collector;

   localparam int W   = 7;
   localparam int WIN = 5;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] inp;
   logic         inp_valid;
   logic         inp_ready;
   logic [W-1:0] outp;
   logic         outp_valid;
   logic         outp_ready;
`ifdef DTC_VOTE_FLUSH_EN
   logic         flush;
`endif

   int checks = 0;
   int errors = 0;

   logic [W-1:0] samples[$];
   logic [W-1:0] exp_q[$];
   bit           m_accum = 1'b1;

   dtc_vote_collector #(
      .WIDTH (W),
      .WINDOW(WIN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inp       (inp),
      .inp_valid (inp_valid),
      .inp_ready (inp_ready),
      .outp      (outp),
      .outp_valid(outp_valid),
      .outp_ready(outp_ready)
`ifdef DTC_VOTE_FLUSH_EN
      ,
      .flush     (flush)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] majority(input logic [W-1:0] s[$]);
      logic [W-1:0] r;
      int ones;
      r = '0;
      for (int b = 0; b < W; b++) begin
         ones = 0;
         foreach (s[k]) if (s[k][b]) ones++;
         r[b] = (2 * ones > s.size());
      end
      return r;
   endfunction

   // One clock: score any result handshake, advance the model, then check outputs.
   task automatic tick();
      logic         acc, rel, fl;
      logic [W-1:0] code;
      logic [W-1:0] e;
      code = inp;
      acc  = rst_n && m_accum && inp_valid;
      rel  = rst_n && !m_accum && outp_ready;
      fl   = 1'b0;
`ifdef DTC_VOTE_FLUSH_EN
      fl   = rst_n && m_accum && flush;
`endif
      if (rel) begin
         if (exp_q.size() == 0) begin
            check("result_expected", 32'(outp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("result", 32'(outp), 32'(e));
         end
      end
      @(posedge clk);
      #1;
      if (acc) samples.push_back(code);
      if ((acc && samples.size() == WIN) || (fl && samples.size() > 0)) begin
         exp_q.push_back(majority(samples));
         samples.delete();
         m_accum = 1'b0;
      end
      if (rel) m_accum = 1'b1;
      check("inp_ready", 32'(inp_ready), 32'(m_accum));
      check("outp_valid", 32'(outp_valid), 32'(!m_accum));
      if (!m_accum && exp_q.size() > 0) check("outp_hold", 32'(outp), 32'(exp_q[0]));
   endtask

   task automatic send(input logic [W-1:0] code, input logic valid);
      inp       = code;
      inp_valid = valid;
      tick();
   endtask

   // Asserts reset mid-cycle, checks outputs clear immediately, releases away from the edge.
   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_outp", 32'(outp), 32'd0);
      check("rst_outp_valid", 32'(outp_valid), 32'd0);
      samples.delete();
      exp_q.delete();
      m_accum = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_inp_ready", 32'(inp_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] maj_codes[5];
      maj_codes = '{7'b0110111, 7'b0110111, 7'b1011011, 7'b0000000, 7'b0110111};

      rst_n      = 1'b0;
      inp        = '0;
      inp_valid  = 1'b0;
      outp_ready = 1'b0;
`ifdef DTC_VOTE_FLUSH_EN
      flush      = 1'b0;
`endif
      @(posedge clk);
      #1;
      check("init_outp", 32'(outp), 32'd0);
      check("init_outp_valid", 32'(outp_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      check("init_inp_ready", 32'(inp_ready), 32'd1);

      // Majority window, back-to-back
      foreach (maj_codes[k]) send(maj_codes[k], 1'b1);
      check("maj_outp", 32'(outp), 32'(7'b0110111));

      // Backpressure with input still offered
      for (int c = 0; c < 10; c++) send(7'b1111111, 1'b1);
      outp_ready = 1'b1;
      send(7'b1111111, 1'b1);
      outp_ready = 1'b0;

      // Fresh window, then reset while the result is pending
      for (int c = 0; c < 3; c++) send(7'b1000000, 1'b1);
      for (int c = 0; c < 2; c++) send(7'b0000000, 1'b1);
      check("fresh_outp", 32'(outp), 32'(7'b1000000));
      do_reset();

      // Gapped input: zeros only on invalid cycles
      for (int c = 0; c < 10; c++) begin
         if (c % 2 == 0) send(7'b1111111, 1'b1);
         else            send(7'b0000000, 1'b0);
      end
      check("gap_outp", 32'(outp), 32'(7'b1111111));
      outp_ready = 1'b1;
      send('0, 1'b0);
      outp_ready = 1'b0;

      // Mid-window reset discards partial counts
      for (int c = 0; c < 3; c++) send(7'b1111111, 1'b1);
      do_reset();
      for (int c = 0; c < 5; c++) send(7'b0000001, 1'b1);
      check("midrst_outp", 32'(outp), 32'(7'b0000001));
      outp_ready = 1'b1;
      send('0, 1'b0);
      outp_ready = 1'b0;

`ifdef DTC_VOTE_FLUSH_EN
      send(7'b1010101, 1'b1);
      send(7'b1010101, 1'b1);
      send(7'b0101010, 1'b1);
      flush = 1'b1;
      send('0, 1'b0);
      flush = 1'b0;
      check("flush_outp", 32'(outp), 32'(7'b1010101));
      outp_ready = 1'b1;
      send('0, 1'b0);
      outp_ready = 1'b0;

      flush = 1'b1;
      send('0, 1'b0);
      send('0, 1'b0);
      flush = 1'b0;
      check("flush_empty", 32'(outp_valid), 32'd0);

      // Flush with a single same-cycle sample
      flush = 1'b1;
      send(7'b0011001, 1'b1);
      flush = 1'b0;
      check("flush_one", 32'(outp), 32'(7'b0011001));
      outp_ready = 1'b1;
      send('0, 1'b0);
      outp_ready = 1'b0;

      // Flush coinciding with the last sample of a full window
      for (int c = 0; c < 4; c++) send(7'b1100110, 1'b1);
      flush = 1'b1;
      send(7'b0000000, 1'b1);
      flush = 1'b0;
      check("flush_full", 32'(outp), 32'(7'b1100110));
      outp_ready = 1'b1;
      send('0, 1'b0);
      outp_ready = 1'b0;
`endif

      // Random traffic on both handshakes
      for (int c = 0; c < 120; c++) begin
         outp_ready = ($urandom_range(0, 2) != 0);
         send(W'($urandom), ($urandom_range(0, 3) != 0));
      end

      outp_ready = 1'b1;
      inp_valid  = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dtc_vote_collector.md
# dtc_vote_collector

Downstream consumer for the decision-tree classifier stage. It accepts a stream of WIDTH-bit classifier output codes over a valid/ready handshake and keeps a per-bit vote count over a window of WINDOW accepted codes. It then emits one registered majority code per window over a second valid/ready handshake. It sits between the combinational classifier and the result sink, smoothing per-sample decisions into windowed labels.

## Interface
- WIDTH, 7: bit width of classifier codes (input and output).
- WINDOW, 5: number of accepted codes per vote; legal range 1..255.
- CW (localparam), $clog2(WINDOW+1): width of the sample counter and of each per-bit counter.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inp  in  WIDTH  classifier code.
- inp_valid  in  1  inp holds a code.
- inp_ready  out  1  block accepts inp this cycle.
- outp  out  WIDTH  registered majority code.
- outp_valid  out  1  outp holds a result.
- outp_ready  in  1  sink accepts outp this cycle.
- flush  in  1  present only with DTC_VOTE_FLUSH_EN; force early emit.

## Operation
- Two states: ACCUM (reset state) and EMIT.
- inp_ready = (state == ACCUM). It is combinational from state only and has no dependency on outp_ready (no bypass).
- ACCUM:
  - A code is accepted on a cycle where inp_valid && inp_ready.
  - On accept, the sample count n increments by 1.
  - On accept, each per-bit counter cnt[i] increments by 1 where inp[i] = 1.
  - On the accept that makes n == WINDOW, the block registers outp[i] = (2*cnt_next[i] > WINDOW), where cnt_next includes the current sample.
  - On that same accept, outp_valid is set and state goes to EMIT.
- Vote rule:
  - Strict majority. A tie (even WINDOW, 2*cnt == WINDOW) yields 0.
  - Comparison uses CW+1 bits; no division.
- EMIT:
  - outp and outp_valid are held stable.
  - inp_valid is ignored; no sample is counted.
  - On outp_valid && outp_ready, the block clears n and all cnt[i] to 0, clears outp_valid, and returns to ACCUM.
  - outp keeps its last value after the handshake. Only outp_valid qualifies it.
- Counters never exceed WINDOW, so there is no wrap-around.

## Timing
- Reset (rst_n low, asynchronous):
  - state = ACCUM, n = 0, cnt[i] = 0.
  - outp = 0, outp_valid = 0.
  - inp_ready = 1 once in ACCUM.
- Latency: last sample of a window accepted at edge t -> outp_valid = 1 from edge t (visible in cycle t+1).
- Return to input: result handshake at edge u -> inp_ready = 1 in cycle u+1.
- Throughput: at most one result per WINDOW+1 cycles with continuous valid/ready.
- Reset mid-window or mid-EMIT discards the partial counts and any pending result immediately.

## Configuration
- DTC_VOTE_FLUSH_EN defined:
  - The flush port exists.
  - flush = 1 in ACCUM with n_next >= 1 forces an emit with outp[i] = (2*cnt_next[i] > n_next). n_next and cnt_next include any sample accepted in the same cycle.
  - flush is ignored when n_next == 0 and in EMIT.
  - If the WINDOW-th sample and flush coincide, the normal window rule applies; the result is identical.
- DTC_VOTE_FLUSH_EN undefined:
  - No flush port; results are emitted only on full windows.
  - All other behaviour is identical.

## Test plan
- Reset: assert rst_n = 0 asynchronously mid-cycle -> outp = 0000000, outp_valid = 0 immediately; after release inp_ready = 1.
- Majority, WINDOW = 5: accept 0110111, 0110111, 1011011, 0000000, 0110111 back-to-back -> outp = 0110111 with outp_valid high the cycle after the 5th accept.
- Backpressure: hold outp_ready = 0 for 10 cycles after the result with inp_valid = 1 -> outp stable, inp_ready = 0, no count change. Then outp_ready = 1 for one cycle -> inp_ready = 1 next cycle, and the next window starts from zero.
- Gapped input: toggle inp_valid every cycle while sending five 1111111 codes; present 0000000 only in invalid cycles -> outp = 1111111 after exactly 5 handshakes.
- Mid-window reset: accept three 1111111 codes, pulse rst_n low, then accept five 0000001 codes -> outp = 0000001.
- Flush (macro on):
  - Accept 1010101, 1010101, 0101010, then flush = 1 -> outp = 1010101 next cycle.
  - flush = 1 with n = 0 -> outp_valid stays 0.
